// File: rtl/tank_sprite_engine.sv
// tank_sprite_engine: one up-facing ROM rotated to four facings, animated, palettised; 3-clock pixel pipeline.
// Optional blinking is compiled in with TANK_SPRITE_FLASH_EN.
module tank_sprite_engine #(
   parameter int SIZE = 32,
   parameter int NUM_FRAMES = 2,
   parameter int NUM_PALETTES = 4,
   parameter int ANIM_DIV = 8,
   parameter int FLASH_DIV = 4,
   parameter logic [2*NUM_FRAMES*SIZE*SIZE-1:0] ROM_INIT = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      frame_tick,
   input  logic                      moving,
   input  logic                      flash,
   input  logic                      px_valid,
   input  logic [$clog2(SIZE)-1:0]   px_x,
   input  logic [$clog2(SIZE)-1:0]   px_y,
   input  logic [1:0]                dir,
   input  logic [1:0]                palette_sel,
   output logic                      out_valid,
   output logic [3:0]                red,
   output logic [3:0]                green,
   output logic [3:0]                blue,
   output logic                      out_transparent
);
   localparam int W = $clog2(SIZE);
   localparam int FW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1;
   localparam int CW = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
   localparam int AW = FW + 2*W;
   localparam logic [CW-1:0] ANIM_LAST = CW'(ANIM_DIV - 1);
   localparam logic [11:0] PAL [4][4] = '{
      '{12'h000, 12'h760, 12'hEC2, 12'hFF8},
      '{12'h000, 12'h050, 12'h3B3, 12'hAFA},
      '{12'h000, 12'h555, 12'hAAA, 12'hFFF},
      '{12'h000, 12'h600, 12'hC22, 12'hF88}
   };

   // Built-in artwork: treads whose stripes shift per frame, hull, and a barrel pointing up.
   function automatic logic [2*NUM_FRAMES*SIZE*SIZE-1:0] tank_art();
      logic [2*NUM_FRAMES*SIZE*SIZE-1:0] r;
      logic [1:0] c;
      r = '0;
      for (int f = 0; f < NUM_FRAMES; f++)
         for (int y = 0; y < SIZE; y++)
            for (int x = 0; x < SIZE; x++) begin
               c = 2'd0;
               if ((x < SIZE/4 || x >= SIZE - SIZE/4) && y >= SIZE/8)
                  c = ((y/2 + f) % 2 == 0) ? 2'd1 : 2'd2;
               else if (y >= SIZE/4 && y < SIZE - SIZE/8)
                  c = 2'd2;
               if (x >= SIZE/2 - SIZE/16 && x < SIZE/2 + SIZE/16 && y < SIZE/2)
                  c = 2'd3;
               r[2*((f*SIZE + y)*SIZE + x) +: 2] = c;
            end
      return r;
   endfunction

   // An all-zero image is useless, so it selects the built-in artwork.
   localparam logic [2*NUM_FRAMES*SIZE*SIZE-1:0] ROM = (ROM_INIT == '0) ? tank_art() : ROM_INIT;

   logic [W-1:0]  sx, sy;
   logic [1:0]    pal_eff, pal1, pal2, idx2;
   logic [AW-1:0] addr1;
   logic          v1, v2, blank;
   logic [CW-1:0] anim_cnt;
   logic [FW-1:0] anim_frame;

   always_comb begin
      sx = dir == 2'd0 ? px_x : dir == 2'd1 ? px_y : dir == 2'd2 ? ~px_x : ~px_y;
      sy = dir == 2'd0 ? px_y : dir == 2'd1 ? ~px_x : dir == 2'd2 ? ~px_y : px_x;
      pal_eff = ({30'd0, palette_sel} < NUM_PALETTES) ? palette_sel : 2'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         out_valid <= 1'b0;
         {red, green, blue} <= 12'h000;
         out_transparent <= 1'b1;
         anim_cnt <= '0;
         anim_frame <= '0;
      end else begin
         v1 <= px_valid;
         v2 <= v1;
         out_valid <= v2;
         if (frame_tick && moving) begin
            anim_cnt <= (anim_cnt == ANIM_LAST) ? '0 : anim_cnt + 1'b1;
            if (anim_cnt == ANIM_LAST)
               anim_frame <= (NUM_FRAMES == 1) ? '0 : anim_frame + 1'b1;
         end
         if (v2) begin
            {red, green, blue} <= blank ? 12'h000 : PAL[pal2][idx2];
            out_transparent <= blank || idx2 == 2'd0;
         end
      end
      addr1 <= {anim_frame, sy, sx};
      pal1 <= pal_eff;
      idx2 <= ROM[{addr1, 1'b0} +: 2];
      pal2 <= pal1;
   end

`ifdef TANK_SPRITE_FLASH_EN
   localparam int LW = FLASH_DIV > 1 ? $clog2(FLASH_DIV) : 1;
   localparam logic [LW-1:0] FLASH_LAST = LW'(FLASH_DIV - 1);
   logic [LW-1:0] flash_cnt;
   logic          flash_phase;

   always_ff @(posedge clk) begin
      if (reset || !flash) begin
         flash_cnt <= '0;
         flash_phase <= 1'b0;
      end else if (frame_tick) begin
         flash_cnt <= (flash_cnt == FLASH_LAST) ? '0 : flash_cnt + 1'b1;
         if (flash_cnt == FLASH_LAST)
            flash_phase <= ~flash_phase;
      end
   end

   assign blank = flash_phase;
`else
   logic unused_flash;
   assign unused_flash = flash & (FLASH_DIV != 0);
   assign blank = 1'b0;
`endif
endmodule

// File: tb/tb_tank_sprite_engine.sv
// tb_tank_sprite_engine: directed checks of rotation, animation, palettes, streaming and blinking.
module tb_tank_sprite_engine;
   logic clk = 1'b0;
   logic reset, frame_tick, moving, flash, px_valid;
   logic [4:0] px_x, px_y;
   logic [1:0] dir, palette_sel;
   logic out_valid, out_transparent, out_valid2, out_transparent2;
   logic [3:0] red, green, blue, red2, green2, blue2;
   logic [12:0] got, got2, expv;
   int pass_cnt = 0, total_cnt = 0;
   int mframe = 0, mcnt = 0, fcnt = 0, fphase = 0;
   int zx, zy, qx, qy;

   always #5 clk = ~clk;
   assign got = {out_transparent, red, green, blue};
   assign got2 = {out_transparent2, red2, green2, blue2};

   function automatic int pat(int a);
      return ((a ^ (a >> 2) ^ (a >> 3) ^ (a >> 7) ^ (a >> 9)) + (a >> 5) + 3 * (a >> 10)) & 3;
   endfunction

   function automatic logic [4095:0] tb_rom();
      logic [4095:0] r;
      for (int a = 0; a < 2048; a++) r[2*a +: 2] = 2'(pat(a));
      return r;
   endfunction

   localparam logic [4095:0] TB_ROM = tb_rom();

   function automatic logic [11:0] pal_rgb(int p, int i);
      case (p)
         0: return i == 1 ? 12'h760 : i == 2 ? 12'hEC2 : 12'hFF8;
         1: return i == 1 ? 12'h050 : i == 2 ? 12'h3B3 : 12'hAFA;
         2: return i == 1 ? 12'h555 : i == 2 ? 12'hAAA : 12'hFFF;
         default: return i == 1 ? 12'h600 : i == 2 ? 12'hC22 : 12'hF88;
      endcase
   endfunction

   function automatic logic [12:0] model(int fr, int x, int y, int d, int p, int np);
      int sx, sy, idx;
      sx = d == 0 ? x : d == 1 ? y : d == 2 ? 31 - x : 31 - y;
      sy = d == 0 ? y : d == 1 ? 31 - x : d == 2 ? 31 - y : x;
      idx = pat(fr * 1024 + sy * 32 + sx);
      if (idx == 0) return 13'h1000;
      return {1'b0, pal_rgb(p >= np ? 0 : p, idx)};
   endfunction

   tank_sprite_engine #(.ROM_INIT(TB_ROM)) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .moving(moving), .flash(flash),
      .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .dir(dir), .palette_sel(palette_sel),
      .out_valid(out_valid), .red(red), .green(green), .blue(blue), .out_transparent(out_transparent));

   tank_sprite_engine #(.NUM_PALETTES(2), .ROM_INIT(TB_ROM)) dut2 (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .moving(moving), .flash(flash),
      .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .dir(dir), .palette_sel(palette_sel),
      .out_valid(out_valid2), .red(red2), .green(green2), .blue(blue2), .out_transparent(out_transparent2));

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int x, int y, int d, int p);
      px_x = 5'(x);
      px_y = 5'(y);
      dir = 2'(d);
      palette_sel = 2'(p);
      px_valid = 1'b1;
   endtask

   task automatic send(int x, int y, int d, int p);
      drive(x, y, d, p);
      cycle();
      px_valid = 1'b0;
      cycle();
      cycle();
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      if (moving) begin
         if (mcnt == 7) begin
            mcnt = 0;
            mframe ^= 1;
         end else mcnt++;
      end
`ifdef TANK_SPRITE_FLASH_EN
      if (!flash) begin
         fcnt = 0;
         fphase = 0;
      end else if (fcnt == 3) begin
         fcnt = 0;
         fphase ^= 1;
      end else fcnt++;
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1;
      px_valid = 1'b1;
      cycle();
      cycle();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", out_valid);
      else pass_cnt++;
      total_cnt++;
      if (got !== 13'h1000) $display("FAIL reset_outputs got=%h want=1000", got);
      else pass_cnt++;
      reset = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         cycle();
         total_cnt++;
         if (out_valid !== (k == 3)) $display("FAIL latency_cycle%0d got=%b want=%b", k, out_valid, k == 3);
         else pass_cnt++;
      end
      px_valid = 1'b0;
      repeat (3) cycle();
   endtask

   task automatic test_animation();
      moving = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         send(7, 12, i % 4, i % 4);
         expv = model(mframe, 7, 12, i % 4, i % 4, 4);
         total_cnt++;
         if (got !== expv) $display("FAIL anim_tick%0d got=%h want=%h", i, got, expv);
         else pass_cnt++;
      end
      moving = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         send(7, 12, 0, 0);
         expv = model(mframe, 7, 12, 0, 0, 4);
         total_cnt++;
         if (got !== expv) $display("FAIL anim_frozen%0d got=%h want=%h", i, got, expv);
         else pass_cnt++;
      end
      moving = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         send(7, 12, 1, 1);
         expv = model(mframe, 7, 12, 1, 1, 4);
         total_cnt++;
         if (got !== expv) $display("FAIL anim_resume%0d got=%h want=%h", i, got, expv);
         else pass_cnt++;
      end
      // counter now sits at its last value: the tick-cycle pixel sees the old frame, the next one the new
      frame_tick = 1'b1;
      drive(7, 12, 0, 0);
      cycle();
      frame_tick = 1'b0;
      drive(7, 12, 0, 0);
      cycle();
      px_valid = 1'b0;
      cycle();
      expv = model(mframe, 7, 12, 0, 0, 4);
      total_cnt++;
      if (got !== expv) $display("FAIL tick_same_cycle got=%h want=%h", got, expv);
      else pass_cnt++;
      mcnt = 0;
      mframe ^= 1;
      cycle();
      expv = model(mframe, 7, 12, 0, 0, 4);
      total_cnt++;
      if (got !== expv) $display("FAIL tick_next_cycle got=%h want=%h", got, expv);
      else pass_cnt++;
      repeat (2) cycle();
   endtask

   task automatic test_reset_vs_tick();
      moving = 1'b1;
      repeat (6) tick();
      reset = 1'b1;
      frame_tick = 1'b1;
      cycle();
      reset = 1'b0;
      frame_tick = 1'b0;
      mcnt = 0;
      mframe = 0;
      repeat (7) tick();
      send(7, 12, 0, 0);
      expv = model(mframe, 7, 12, 0, 0, 4);
      total_cnt++;
      if (got !== expv) $display("FAIL reset_beats_tick got=%h want=%h", got, expv);
      else pass_cnt++;
      tick();
      send(7, 12, 0, 0);
      expv = model(mframe, 7, 12, 0, 0, 4);
      total_cnt++;
      if (got !== expv) $display("FAIL count_after_reset got=%h want=%h", got, expv);
      else pass_cnt++;
      moving = 1'b0;
   endtask

   task automatic test_rotation();
      for (int d = 0; d < 4; d++) begin
         send(16, 0, d, 0);
         expv = model(mframe, 16, 0, d, 0, 4);
         total_cnt++;
         if (got !== expv) $display("FAIL rot_16_0_dir%0d got=%h want=%h", d, got, expv);
         else pass_cnt++;
         send(5, 27, d, 3);
         expv = model(mframe, 5, 27, d, 3, 4);
         total_cnt++;
         if (got !== expv) $display("FAIL rot_5_27_dir%0d got=%h want=%h", d, got, expv);
         else pass_cnt++;
      end
   endtask

   task automatic test_palette();
      zx = -1;
      qx = -1;
      for (int y = 0; y < 32; y++)
         for (int x = 0; x < 32; x++)
            if (model(mframe, x, y, 0, 0, 4) == 13'h1000) begin
               zx = x;
               zy = y;
            end else begin
               qx = x;
               qy = y;
            end
      for (int p = 0; p < 4; p++) begin
         send(zx, zy, 0, p);
         total_cnt++;
         if (got !== 13'h1000) $display("FAIL transparent_pal%0d got=%h want=1000", p, got);
         else pass_cnt++;
         send(qx, qy, 0, p);
         expv = model(mframe, qx, qy, 0, p, 4);
         total_cnt++;
         if (got !== expv) $display("FAIL opaque_pal%0d got=%h want=%h", p, got, expv);
         else pass_cnt++;
         expv = model(mframe, qx, qy, 0, p, 2);
         total_cnt++;
         if (got2 !== expv) $display("FAIL two_pal_sel%0d got=%h want=%h", p, got2, expv);
         else pass_cnt++;
      end
      repeat (3) cycle();
      expv = model(mframe, qx, qy, 0, 3, 4);
      total_cnt++;
      if ({out_valid, got} !== {1'b0, expv}) $display("FAIL hold_when_idle got=%b/%h want=0/%h", out_valid, got, expv);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [12:0] eq [1024];
      for (int i = 0; i < 1026; i++) begin
         if (i < 1024) begin
            drive(i % 32, i / 32, i % 4, (i / 3) % 4);
            eq[i] = model(mframe, i % 32, i / 32, i % 4, (i / 3) % 4, 4);
         end else px_valid = 1'b0;
         cycle();
         if (i >= 2) begin
            total_cnt++;
            if ({out_valid, got} !== {1'b1, eq[i-2]})
               $display("FAIL burst_px%0d got=%b/%h want=1/%h", i - 2, out_valid, got, eq[i-2]);
            else pass_cnt++;
         end
      end
      cycle();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL burst_end got=%b want=0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_flash();
      flash = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         tick();
         send(qx, qy, 0, 1);
         expv = fphase != 0 ? 13'h1000 : model(mframe, qx, qy, 0, 1, 4);
         total_cnt++;
         if (got !== expv) $display("FAIL flash_tick%0d got=%h want=%h", t, got, expv);
         else pass_cnt++;
      end
      flash = 1'b0;
      fcnt = 0;
      fphase = 0;
      send(qx, qy, 0, 1);
      expv = model(mframe, qx, qy, 0, 1, 4);
      total_cnt++;
      if (got !== expv) $display("FAIL flash_release got=%h want=%h", got, expv);
      else pass_cnt++;
   endtask

   initial begin
      reset = 1'b1;
      frame_tick = 1'b0;
      moving = 1'b0;
      flash = 1'b0;
      px_valid = 1'b0;
      px_x = '0;
      px_y = '0;
      dir = '0;
      palette_sel = '0;
      test_reset();
      test_animation();
      test_reset_vs_tick();
      test_rotation();
      test_palette();
      test_back_to_back();
      test_flash();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
